// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared state, frame-control and code-conversion items
// for the dual-DAC SPI scheduler.
package dac_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    SHIFT_A,
    GAP,
    LOAD_B,
    SHIFT_B,
    LATCH
  } state_t;

  localparam logic CH_A        = 1'b0;
  localparam logic CH_B        = 1'b1;
  localparam logic CTRL_BUF    = 1'b0;
  localparam logic CTRL_GA_N   = 1'b1;
  localparam logic CTRL_SHDN_N = 1'b1;

  localparam int CLAMP_MIN   = -2048;
  localparam int CLAMP_MAX   = 2047;
  localparam int CODE_OFFSET = 2048;

  function automatic logic [11:0] to_code(
    input logic signed [31:0] s
  );
    logic signed [31:0] c;
    c = s;
    if (s < CLAMP_MIN)
      c = CLAMP_MIN;
    else if (s > CLAMP_MAX)
      c = CLAMP_MAX;
    return 12'(c + CODE_OFFSET);
  endfunction

  function automatic logic [15:0] make_frame(
    input logic        ch,
    input logic [11:0] code
  );
    return {ch, CTRL_BUF, CTRL_GA_N,
            CTRL_SHDN_N, code};
  endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// dac_spi_shifter: 16-bit MSB-first SPI shifter with SCLK divider,
// bit counter and a done strobe on the last high half.
module dac_spi_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] frame,
  output logic        active,
  output logic        sclk,
  output logic        mosi,
  output logic        done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [15:0] sr;
  logic [7:0]  div;
  logic [3:0]  bitc;
  logic        div_end;

  assign div_end = (div == DIV_LAST);
  assign done    = active && sclk && div_end
                   && (bitc == 4'd15);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr     <= '0;
      div    <= '0;
      bitc   <= '0;
      active <= 1'b0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
    end else if (load) begin
      sr     <= frame;
      mosi   <= frame[15];
      div    <= '0;
      bitc   <= '0;
      sclk   <= 1'b0;
      active <= 1'b1;
    end else if (active) begin
      if (div_end) begin
        div  <= '0;
        sclk <= ~sclk;
        // data advances only on the falling edge
        if (sclk) begin
          sr   <= {sr[14:0], 1'b0};
          mosi <= sr[14];
          bitc <= bitc + 4'd1;
          if (bitc == 4'd15)
            active <= 1'b0;
        end
      end else begin
        div <= div + 8'd1;
      end
    end
  end

endmodule

// File: rtl/dac_spi_scheduler.sv
// dac_spi_scheduler: sequences channel A/B frames onto a shared DAC SPI bus.
// DAC_LDAC_SYNC_EN adds a LATCH phase pulsing ldac_n; otherwise ldac_n is tied low.
module dac_spi_scheduler
  import dac_sched_pkg::*;
#(
  parameter int N       = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sample_tick,
  input  logic [1:0]          run,
  input  logic signed [N-1:0] sample_a,
  input  logic signed [N-1:0] sample_b,
  output logic                busy,
  output logic                overrun,
  output logic                spi_cs_n,
  output logic                spi_sclk,
  output logic                spi_mosi,
  output logic                ldac_n
);

  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
`ifdef DAC_LDAC_SYNC_EN
  localparam logic [7:0] LAT_LAST = 8'(CS_GAP + 1);
`endif

  state_t      state_q, state_n;
  logic [7:0]  cnt_q, cnt_n;
  logic [15:0] frame_b_q;
  logic        run_b_q;
  logic        overrun_q;
  logic        cap, load, fin;
  logic [15:0] ld_frame;
  logic [15:0] frame_a_in, frame_b_in;
  logic        sh_active, sh_done;
`ifndef DAC_LDAC_SYNC_EN
  logic        tail_q, tail_n;
`endif

  assign frame_a_in =
    make_frame(CH_A, to_code(32'(sample_a)));
  assign frame_b_in =
    make_frame(CH_B, to_code(32'(sample_b)));

  always_comb begin
    state_n  = state_q;
    cnt_n    = '0;
    cap      = 1'b0;
    load     = 1'b0;
    fin      = 1'b0;
    ld_frame = frame_b_q;
`ifndef DAC_LDAC_SYNC_EN
    tail_n   = tail_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (en && sample_tick && (run != 2'b00)) begin
          cap  = 1'b1;
          load = 1'b1;
          if (run[0]) begin
            state_n  = LOAD_A;
            ld_frame = frame_a_in;
          end else begin
            state_n  = LOAD_B;
            ld_frame = frame_b_in;
          end
        end
      end
      LOAD_A: state_n = SHIFT_A;
      SHIFT_A: begin
        if (sh_done) begin
          if (run_b_q && en)
            state_n = GAP;
          else
            fin = 1'b1;
        end
      end
      GAP: begin
        cnt_n = cnt_q + 8'd1;
        if (cnt_q == GAP_LAST) begin
          cnt_n = '0;
`ifndef DAC_LDAC_SYNC_EN
          if (tail_q) begin
            state_n = IDLE;
            tail_n  = 1'b0;
          end else
`endif
          begin
            load    = 1'b1;
            state_n = LOAD_B;
          end
        end
      end
      LOAD_B: state_n = SHIFT_B;
      SHIFT_B: begin
        if (sh_done)
          fin = 1'b1;
      end
`ifdef DAC_LDAC_SYNC_EN
      LATCH: begin
        cnt_n = cnt_q + 8'd1;
        if (cnt_q == LAT_LAST)
          state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
    // last frame done: wait out the CS gap before release
    if (fin) begin
`ifdef DAC_LDAC_SYNC_EN
      state_n = LATCH;
`else
      state_n = GAP;
      tail_n  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_b_q <= '0;
      run_b_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      overrun_q <= sample_tick && (state_q != IDLE);
      if (cap) begin
        frame_b_q <= frame_b_in;
        run_b_q   <= run[1];
      end
    end
  end

`ifdef DAC_LDAC_SYNC_EN
  logic ldac_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ldac_q <= 1'b1;
    else
      ldac_q <= !((state_n == LATCH)
                  && (cnt_n >= 8'(CS_GAP)));
  end

  assign ldac_n = ldac_q;
`else
  always_ff @(posedge clk) begin
    if (!rst_n)
      tail_q <= 1'b0;
    else
      tail_q <= tail_n;
  end

  assign ldac_n = 1'b0;
`endif

  dac_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .frame  (ld_frame),
    .active (sh_active),
    .sclk   (spi_sclk),
    .mosi   (spi_mosi),
    .done   (sh_done)
  );

  assign spi_cs_n = ~sh_active;
  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;

endmodule

// File: doc/dac_spi_scheduler.md
DAC_SPI_SCHEDULER -- requirements
Module: dac_spi_scheduler

Interface
REQ-001 SHALL have parameter N, default 16: width of the signed sample inputs.
REQ-002 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk cycles, legal range 1..255.
REQ-003 SHALL have parameter CS_GAP, default 2: minimum number of clk cycles spi_cs_n stays high between frames.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: global enable.
REQ-007 SHALL have port sample_tick, input, 1 bit: one-cycle strobe at the sample rate.
REQ-008 SHALL have port run, input, 2 bits: bit0 enables channel A; bit1 enables channel B.
REQ-009 SHALL have ports sample_a and sample_b, input, N bits each, signed: the channel A and channel B generator outputs.
REQ-010 SHALL have port busy, output, 1 bit: high while a transaction sequence is in progress.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a sample_tick is dropped.
REQ-012 SHALL have ports spi_cs_n, spi_sclk and spi_mosi, output, 1 bit each: the shared dual-DAC SPI bus.
REQ-013 SHALL have port ldac_n, output, 1 bit: DAC latch strobe, active low.

Function
REQ-014 SHALL use FSM states IDLE, LOAD_A, SHIFT_A, GAP, LOAD_B, SHIFT_B, LATCH.
- Transitions: IDLE->LOAD_A (or LOAD_B); LOAD_A->SHIFT_A->GAP->LOAD_B->SHIFT_B->LATCH->IDLE.
REQ-015 SHALL, in IDLE with en=1 and sample_tick=1 and run!=0, capture sample_a, sample_b and run in the same cycle and leave IDLE.
- A channel whose captured run bit is 0 is skipped.
- With only B running, the FSM goes IDLE->LOAD_B directly.
- With only A running, the FSM goes SHIFT_A->LATCH.
REQ-016 SHALL, on sample_tick with run=0, stay in IDLE and produce no bus activity.
REQ-017 SHALL, on sample_tick while busy=1, drop the tick and pulse overrun for exactly 1 cycle; captured samples are not changed.
REQ-018 SHALL convert each captured sample to a 12-bit code: clamp to [-2048, 2047], then add 2048.
- Examples: -32768->0x000, 0->0x800, 2047->0xFFF, 5000->0xFFF.
REQ-019 SHALL build each 16-bit frame as: bit15 = channel (A=0, B=1), bit14 = BUF=0, bit13 = GA_n=1, bit12 = SHDN_n=1, bits11:0 = code; frames are sent MSB first.
REQ-020 SHALL use SPI timing as follows.
- spi_sclk idles low.
- spi_mosi changes only while spi_sclk is low.
- Each bit lasts 2*CLK_DIV cycles (low half, then high half).
- Exactly 16 rising edges per frame.
REQ-021 SHALL drive spi_cs_n low one cycle after the capture cycle, with MSB valid on spi_mosi in that same cycle.
REQ-022 SHALL raise spi_cs_n on the cycle after the 16th high half ends.
REQ-023 SHALL hold spi_cs_n high for exactly CS_GAP cycles between the A and B frames.
REQ-024 SHALL, in LATCH, drive ldac_n low for 2 cycles, starting CS_GAP cycles after the final spi_cs_n rise, then return to IDLE.
REQ-025 SHALL hold busy high from the first spi_cs_n low cycle through the last LATCH cycle, and busy SHALL fall the cycle IDLE is re-entered.
REQ-026 SHALL, if en falls mid-frame, complete that frame, skip any remaining frame, still perform LATCH, then return to IDLE.
REQ-027 SHALL ignore changes to sample_a, sample_b and run after capture until the next accepted tick.

Reset
REQ-028 SHALL, while rst_n=0 at a clk edge, force the following regardless of state:
- state=IDLE, busy=0, overrun=0
- spi_cs_n=1, spi_sclk=0, spi_mosi=0, ldac_n=1
- shift register and bit/divider counters cleared
REQ-029 SHALL, on reset mid-frame, abandon the frame with no LDAC pulse; the first tick after release starts a fresh sequence.

Configuration
REQ-030 SHALL, with DAC_LDAC_SYNC_EN defined, operate as REQ-024 so that both channels update simultaneously.
REQ-031 SHALL, with DAC_LDAC_SYNC_EN undefined, omit the LATCH state, hold ldac_n=0 permanently (the DAC updates on each spi_cs_n rise), and return to IDLE CS_GAP cycles after the final spi_cs_n rise.

Structure
REQ-032 SHALL place the state enum, the frame control bit constants, the clamp limits (-2048/2047) and the offset (2048) in shared package dac_sched_pkg.
REQ-033 SHALL implement sub-module dac_spi_shifter (16-bit load/shift, CLK_DIV divider, bit counter, done pulse), instantiated once and time-shared by both channels.

Verification
REQ-034 SHALL cover: run=2'b11, sample_a=0, sample_b=-1, CLK_DIV=2, macro defined -> frames 0x3800 then 0xB7FF, CS gap 2 cycles, 2-cycle ldac_n low, busy high for exactly 2*64+2+2+2 cycles.
REQ-035 SHALL cover: run=2'b10, sample_b=30000 -> single frame 0xBFFF; no channel A frame.
REQ-036 SHALL cover: a second sample_tick 10 cycles after the first -> overrun pulses once, and the captured frames are unchanged.
REQ-037 SHALL cover: en dropped during bit 5 of frame A with run=2'b11 -> frame A completes (16 rising edges), no frame B, LDAC pulse occurs.
REQ-038 SHALL cover: rst_n low during SHIFT_B -> next edge spi_cs_n=1, spi_sclk=0, busy=0, ldac_n=1, with no LDAC pulse.
REQ-039 SHALL cover: macro undefined, run=2'b01 -> ldac_n constantly 0, and busy falls CS_GAP cycles after spi_cs_n rises.
